// File: rtl/rs_slot_manager_if.sv
// rs_slot_manager_if: alloc/release request and slot-status bundle for one reservation station.
interface rs_slot_manager_if #(
    parameter int RS_SIZE = 6,
    parameter int TAG_W   = 3,
    parameter int CNT_W   = 3
);
    logic               flush_i;
    logic               alloc_valid_i;
    logic [TAG_W-1:0]   alloc_tag_i;
    logic               alloc_ready_o;
    logic               rel_a_valid_i;
    logic [TAG_W-1:0]   rel_a_tag_i;
    logic               rel_b_valid_i;
    logic [TAG_W-1:0]   rel_b_tag_i;
    logic [RS_SIZE-1:0] free_status_o;
    logic [CNT_W-1:0]   busy_count_o;
    logic               full_o;
    logic               empty_o;
    logic               err_o;
    modport slave (
        input  flush_i, alloc_valid_i, alloc_tag_i, rel_a_valid_i, rel_a_tag_i, rel_b_valid_i, rel_b_tag_i,
        output alloc_ready_o, free_status_o, busy_count_o, full_o, empty_o, err_o
    );
    modport master (
        output flush_i, alloc_valid_i, alloc_tag_i, rel_a_valid_i, rel_a_tag_i, rel_b_valid_i, rel_b_tag_i,
        input  alloc_ready_o, free_status_o, busy_count_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/rs_slot_manager.sv
// rs_slot_manager: busy/free bitmap, occupancy count and sticky protocol-error flag for one reservation station.
module rs_slot_manager #(
    parameter int RS_SIZE = 6,
    parameter int TAG_W   = 3,
    parameter int CNT_W   = 3
) (
    input logic clk,
    input logic rst,
    rs_slot_manager_if.slave bus
);
    localparam logic [TAG_W:0]       SZ  = (TAG_W+1)'(RS_SIZE);
    localparam logic [RS_SIZE-1:0]   ONE = {{(RS_SIZE-1){1'b0}}, 1'b1};
    logic [RS_SIZE-1:0] free_q, free_d, free_rel;
    logic [CNT_W-1:0]   busy_q, busy_d;
    logic               err_q, err_d, a_ok, b_ok, al_ok;
    function automatic logic in_rng(input logic [TAG_W-1:0] t);
        return {1'b0, t} < SZ;
    endfunction
    // Releases land first so that a slot freed this cycle can be recycled by alloc even when full.
    always_comb begin
        a_ok     = bus.rel_a_valid_i && in_rng(bus.rel_a_tag_i) && !free_q[bus.rel_a_tag_i];
        b_ok     = bus.rel_b_valid_i && in_rng(bus.rel_b_tag_i) && !free_q[bus.rel_b_tag_i]
                   && !(a_ok && bus.rel_b_tag_i == bus.rel_a_tag_i);
        free_rel = free_q | (a_ok ? ONE << bus.rel_a_tag_i : '0) | (b_ok ? ONE << bus.rel_b_tag_i : '0);
        al_ok    = bus.alloc_valid_i && in_rng(bus.alloc_tag_i) && free_rel[bus.alloc_tag_i];
        free_d   = bus.flush_i ? '1 : free_rel & ~(al_ok ? ONE << bus.alloc_tag_i : '0);
        busy_d   = bus.flush_i ? '0 : busy_q + CNT_W'(al_ok) - CNT_W'(a_ok) - CNT_W'(b_ok);
        err_d    = err_q | (!bus.flush_i && ((bus.rel_a_valid_i && !a_ok) || (bus.rel_b_valid_i && !b_ok)
                   || (bus.alloc_valid_i && !al_ok)));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q <= '1;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end
    assign bus.free_status_o = free_q;
    assign bus.busy_count_o  = busy_q;
    assign bus.full_o        = busy_q == CNT_W'(RS_SIZE);
    assign bus.empty_o       = busy_q == '0;
    assign bus.alloc_ready_o = !bus.full_o;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_rs_slot_manager.sv
// tb_rs_slot_manager: directed plan plus randomized traffic checked against a per-slot occupancy model.
module tb_rs_slot_manager;
    localparam int N = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    bit m_busy [N];
    bit m_err;
    rs_slot_manager_if #(.RS_SIZE(N), .TAG_W(3), .CNT_W(3)) bus ();
    rs_slot_manager #(.RS_SIZE(N), .TAG_W(3), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_free();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = !m_busy[i];
        return f;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return 7;
    endfunction

    function automatic int m_any_busy();
        int q[$];
        for (int i = 0; i < N; i++) if (m_busy[i]) q.push_back(i);
        return q.size() == 0 ? int'($urandom_range(7)) : q[$urandom_range(q.size()-1)];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic check_all();
        chk("free", 32'(bus.free_status_o), 32'(m_free()));
        chk("busy", 32'(bus.busy_count_o), 32'(m_cnt()));
        chk("full", 32'(bus.full_o), 32'(m_cnt() == N));
        chk("empty", 32'(bus.empty_o), 32'(m_cnt() == 0));
        chk("ready", 32'(bus.alloc_ready_o), 32'(m_cnt() != N));
        chk("err", 32'(bus.err_o), 32'(m_err));
        chk("inv", 32'(bus.busy_count_o), 32'(N - $countones(bus.free_status_o)));
    endtask

    // Model applies release A, then release B, then alloc, one slot at a time.
    task automatic step(input bit fl, input bit av, input int at, input bit rav, input int rat,
                        input bit rbv, input int rbt);
        bus.flush_i = fl; bus.alloc_valid_i = av; bus.alloc_tag_i = 3'(at);
        bus.rel_a_valid_i = rav; bus.rel_a_tag_i = 3'(rat);
        bus.rel_b_valid_i = rbv; bus.rel_b_tag_i = 3'(rbt);
        if (fl) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        end else begin
            if (rav) begin
                if (rat < N && m_busy[rat]) m_busy[rat] = 1'b0; else m_err = 1'b1;
            end
            if (rbv) begin
                if (rbt < N && m_busy[rbt]) m_busy[rbt] = 1'b0; else m_err = 1'b1;
            end
            if (av) begin
                if (at < N && !m_busy[at]) m_busy[at] = 1'b1; else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int t);
        step(0, 1, t, 0, 0, 0, 0);
    endtask

    // Called just after a posedge; reset values must show before the next edge.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        m_reset();
        chk("arst_free", 32'(bus.free_status_o), 32'h3f);
        chk("arst_busy", 32'(bus.busy_count_o), 0);
        chk("arst_empty", 32'(bus.empty_o), 1);
        chk("arst_full", 32'(bus.full_o), 0);
        chk("arst_err", 32'(bus.err_o), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.flush_i = 0; bus.alloc_valid_i = 0; bus.alloc_tag_i = 0;
        bus.rel_a_valid_i = 0; bus.rel_a_tag_i = 0; bus.rel_b_valid_i = 0; bus.rel_b_tag_i = 0;
        m_reset();
        #12 rst = 1'b0;
        idle();
        chk("rst_free", 32'(bus.free_status_o), 32'h3f);
        chk("rst_empty", 32'(bus.empty_o), 1);
        // Fill and drain
        for (int t = 0; t < N; t++) alloc(t);
        chk("fill_free", 32'(bus.free_status_o), 0);
        chk("fill_busy", 32'(bus.busy_count_o), 6);
        chk("fill_ready", 32'(bus.alloc_ready_o), 0);
        for (int t = N-1; t >= 0; t--) begin
            if (t % 2 == 1) step(0, 0, 0, 1, t, 0, 0); else step(0, 0, 0, 0, 0, 1, t);
        end
        chk("drain_free", 32'(bus.free_status_o), 32'h3f);
        chk("drain_err", 32'(bus.err_o), 0);
        // Recycle at full
        for (int t = 0; t < N; t++) alloc(t);
        step(0, 1, 3, 1, 3, 0, 0);
        chk("recyc_free", 32'(bus.free_status_o), 0);
        chk("recyc_busy", 32'(bus.busy_count_o), 6);
        chk("recyc_err", 32'(bus.err_o), 0);
        alloc(2);
        chk("full_alloc_err", 32'(bus.err_o), 1);
        do_reset();
        // Dual release
        alloc(1); alloc(4);
        step(0, 0, 0, 1, 1, 1, 4);
        chk("dual_busy", 32'(bus.busy_count_o), 0);
        chk("dual_err", 32'(bus.err_o), 0);
        alloc(2);
        step(0, 0, 0, 1, 2, 1, 2);
        chk("dbl_busy", 32'(bus.busy_count_o), 0);
        chk("dbl_err", 32'(bus.err_o), 1);
        do_reset();
        // Illegal traffic
        alloc(3);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("ill_rel_free", 32'(bus.free_status_o), 32'h37);
        chk("ill_rel_err", 32'(bus.err_o), 1);
        alloc(6);
        chk("ill_tag_free", 32'(bus.free_status_o), 32'h37);
        alloc(3);
        chk("ill_busy_cnt", 32'(bus.busy_count_o), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("ill_flush_err", 32'(bus.err_o), 1);
        do_reset();
        // Flush with concurrent alloc
        alloc(0); alloc(2); alloc(5);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("flush_free", 32'(bus.free_status_o), 32'h3f);
        chk("flush_busy", 32'(bus.busy_count_o), 0);
        chk("flush_err", 32'(bus.err_o), 0);
        // Randomized traffic with periodic resets
        for (int c = 0; c < 800; c++) begin
            bit fl, av, rav, rbv;
            int at, rat, rbt;
            if (c % 150 == 149) do_reset();
            fl  = ($urandom_range(39) == 0);
            av  = ($urandom_range(9) < 7);
            at  = ($urandom_range(7) < 6) ? m_lowest_free() : int'($urandom_range(7));
            rav = ($urandom_range(9) < 4);
            rat = ($urandom_range(9) < 8) ? m_any_busy() : int'($urandom_range(7));
            rbv = ($urandom_range(9) < 3);
            rbt = ($urandom_range(9) < 8) ? m_any_busy() : int'($urandom_range(7));
            step(fl, av, at, rav, rat, rbv, rbt);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rs_slot_manager.md
# rs_slot_manager

Owns the busy/free bitmap of one reservation station and produces the free-status vector consumed by the free-tag priority table, which returns the lowest-numbered free slot tag. Dispatch writes the slot it was handed back through the alloc port. Issue and wakeup paths return slots through two release ports. The block also keeps an occupancy count, a full/empty indication, and a sticky protocol-error flag for illegal allocate/release traffic.

## Interface
Parameters:
- RS_SIZE, 6: number of RS slots; free-status bit i=1 means slot i is free.
- TAG_W, 3: slot tag width; tags 0..RS_SIZE-1 are legal.
- CNT_W, 3: occupancy counter width, must hold RS_SIZE.

Ports:
- clk  in  1: sole clock; all state updates on posedge.
- rst  in  1: asynchronous, active-high reset.
- flush  in  1: synchronous mispredict flush; frees every slot.
- alloc_valid  in  1: dispatch claims slot alloc_tag this cycle.
- alloc_tag  in  TAG_W: slot being claimed (normally the table's free tag).
- alloc_ready  out  1: = !full; dispatch may only assert alloc_valid when high.
- rel_a_valid / rel_b_valid  in  1 each: release requests.
- rel_a_tag / rel_b_tag  in  TAG_W each: slot being released.
- free_status  out  RS_SIZE: registered free bitmap, fed to the table.
- busy_count  out  CNT_W: number of busy slots, registered.
- full  out  1: busy_count == RS_SIZE.
- empty  out  1: busy_count == 0.
- err  out  1: sticky protocol-error flag.

## Operation
- State: free_status[RS_SIZE-1:0], busy_count, err. full, empty, and alloc_ready decode combinationally from registered state.
- Per-cycle update order, evaluated against current-cycle state:
  1. flush=1: free_status <= all ones, busy_count <= 0. Alloc and release in the same cycle are ignored and do not set err. err holds its value.
  2. Otherwise, releases are applied first, then alloc.
- Release X is legal when its tag is < RS_SIZE and free_status[tag]==0. A legal release sets the bit to 1.
- Release X is illegal when tag >= RS_SIZE or the slot is already free. An illegal release is ignored and sets err.
- rel_a and rel_b with the same legal tag in one cycle free the slot once, decrement busy_count once, and set err (double release).
- Alloc is legal when alloc_tag < RS_SIZE and the slot is free after releases are applied. A legal alloc clears the bit.
- Alloc is illegal when the slot is busy, the tag is out of range, or full=1 at the start of the cycle. An illegal alloc is ignored and sets err.
  - Exception: when full=1 and a legal release frees alloc_tag in the same cycle, the alloc succeeds (slot recycled) and err is not set.
- busy_count next = busy_count + legal_alloc − legal_releases, where legal_releases ∈ {0,1,2} and alloc ∈ {0,1}. The result never leaves 0..RS_SIZE.
- Invariant checked by the bench: busy_count == RS_SIZE − popcount(free_status).
- err clears only on rst.

## Timing
- Reset (async assert, async to clk): free_status = all ones, busy_count = 0, full = 0, empty = 1, alloc_ready = 1, err = 0.
- Release takes effect on deassertion; the first update occurs at the first posedge with rst low.
- One-cycle latency: a request at posedge N is visible on free_status and busy_count after posedge N.
- The table's free tag therefore reflects an allocation from the next cycle onward. Dispatch must not reuse a cycle-N tag in cycle N+1 without seeing the updated status.
- No combinational path from any request input to any output.
- rst asserted mid-operation discards all in-flight requests immediately.

## Test plan
- Reset then idle:
  - Stimulus: release rst, idle.
  - Required: free_status=6'b111111, busy_count=0, empty=1, full=0, err=0.
- Fill and drain:
  - Stimulus: alloc tags 0..5 on consecutive cycles.
  - Required after the 6th edge: free_status=0, busy_count=6, full=1, alloc_ready=0.
  - Stimulus: then release 5..0 alternating across ports A and B.
  - Required: back to all ones, empty=1, err=0.
- Recycle at full:
  - Stimulus: with full=1, same cycle rel_a_tag=3 and alloc_tag=3.
  - Required: free_status stays 0, busy_count stays 6, err=0.
  - Stimulus: alloc_tag=2 alone while full.
  - Required: ignored, err=1.
- Dual release:
  - Stimulus: busy {1,4}, rel_a_tag=1 and rel_b_tag=4 together.
  - Required: busy_count 2→0.
  - Stimulus: busy {2}, rel_a_tag=2 and rel_b_tag=2 together.
  - Required: busy_count 1→0, err=1.
- Illegal traffic:
  - Stimulus: release of free slot 0, alloc_tag=6, alloc of busy slot.
  - Required: each is ignored with no state change except err=1; err stays 1 through a later flush.
- Flush and async reset:
  - Stimulus: busy {0,2,5}, flush=1 together with alloc_tag=1.
  - Required: free_status=6'b111111, busy_count=0, err unchanged.
  - Stimulus: assert rst between clock edges.
  - Required: outputs return to reset values before the next posedge.
